id_stage_param: RTL and testbench
=================================

// Module: id_stage_param
// PURPOSE
//  Parametrised RV32I/RV32E instruction-decode stage for the 5-stage ALU pipeline. Owns the register file.
//  Decodes the IF/ID word, resolves beq/bne/jal/jalr in ID, and detects load-use and branch-operand hazards.
//  Drives a valid/ready-handshaked ID/EX pipeline register, replacing the fixed-width memory_stall decode stage.
// PARAMETERS
//  XLEN   32  datapath width (32 or 64); immediates sign-extended to XLEN
//  NREG   32  architectural registers (16 = RV32E, 32 = RV32I); x0 reads zero
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     reset, synchronous, active-low
//  if_valid     in   1     IF/ID holds an instruction
//  if_ready     out  1     ID accepts if_instr/if_pc this cycle
//  if_instr     in   32    instruction word
//  if_pc        in   XLEN  PC of if_instr
//  wb_en        in   1     write-back strobe
//  wb_rd        in   5     write-back destination
//  wb_data      in   XLEN  write-back data
//  fwd_rd       in   5     destination of instruction in EX/MEM (ALU result ready)
//  fwd_data     in   XLEN  EX/MEM ALU result, used for branch compare/jalr base
//  id_valid     out  1     ID/EX register holds a valid op
//  id_ready     in   1     EX consumes ID/EX this cycle
//  id_rd/rs1/rs2 out 5     register indices (rs1 = 0 for jal/jalr-link)
//  id_op1/op2   out  XLEN  operands (op1 = PC, imm = 4 for jal/jalr)
//  id_imm       out  XLEN  sign-extended immediate
//  id_aluop     out  4     ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8
//  id_alusrc    out  1     1 = op2 from imm
//  id_memrd/id_memwr/id_regwr out 1  control
//  id_illegal   out  1     undecodable opcode or register index >= NREG
//  br_taken     out  1     redirect (combinational; valid when the instruction is accepted)
//  br_target    out  XLEN  redirect target
// BEHAVIOUR
//  - Reset: all ID/EX outputs 0 (id_valid=0); every register-file entry 0.
//  - Register file: write on every edge where wb_en & wb_rd!=0 & wb_rd<NREG, independent of any stall.
//    Same-cycle read of wb_rd returns wb_data (write-through).
//  - Advance: ID/EX loads when (!id_valid | id_ready); otherwise all ID/EX fields hold.
//  - if_ready = (!id_valid | id_ready) & !hazard. Accept = if_valid & if_ready.
//    On accept, ID/EX takes the decode with id_valid=1. On advance without accept, ID/EX takes a bubble
//    (id_valid=0, all control 0).
//  - Load-use hazard: id_valid & id_memrd & id_rd!=0 & id_rd matches a used rs of if_instr -> hazard=1.
//  - Branch hazard: if_instr is beq/bne/jalr & id_valid & id_regwr & id_rd!=0 & id_rd matches a used rs -> hazard=1.
//  - Branch compare forwarding: rs==fwd_rd!=0 uses fwd_data, else the register file. Applies to both
//    operands independently, including rs1==rs2.
//  - br_taken = accept & (jal | jalr | beq&eq | bne&!eq); low while stalled or !if_valid.
//  - br_target: jal/branch = if_pc + imm; jalr = (rs1 + imm) & ~1. Arithmetic is mod 2^XLEN.
//  - Illegal decode: id_illegal=1, control as a bubble (memrd/memwr/regwr=0), id_valid=1.
//  - rst_n low mid-stall: ID/EX cleared next edge; any pending hazard is dropped.
// CONFIGURATION
//  ID_BRANCH_EN defined:   branches and jumps are resolved in ID as above.
//  ID_BRANCH_EN undefined: br_taken is tied 0 and the branch hazard is disabled. The ID/EX register
//    passes cmp operands with aluop=SUB; EX owns redirection. Load-use detection is unchanged.
// TESTING
//  1 reset, then addi x1,x0,5 accepted -> next cycle id_valid=1, id_op1=0, id_imm=5, id_alusrc=1, id_regwr=1.
//  2 lw x2,0(x1) in ID/EX, add x3,x2,x1 offered -> if_ready=0 for 1 cycle, bubble issued, then accepted.
//  3 wb_en=1 wb_rd=4 wb_data=0x77 while id_ready=0 for 3 cycles -> x4=0x77; stall holds ID/EX unchanged.
//  4 fwd_rd=5 fwd_data=9, x6=9, beq x5,x6,+16 at pc 0x100 -> br_taken=1, br_target=0x110.
//  5 NREG=16, add x20,x1,x2 -> id_illegal=1, id_regwr=0; wb_rd=20 write ignored.
//  6 jalr x1,3(x7) with x7=0x200 -> br_target=0x202, id_op1=pc, id_imm=4, id_rs1=0.

Source files
------------

// File: rtl/id_stage_param_if.sv
// IF/ID, write-back, forwarding and ID/EX signal bundle for id_stage_param.
// master = surrounding pipeline, slave = the decode stage.
interface id_stage_param_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            id_valid;
    logic            id_ready;
    logic [4:0]      id_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [XLEN-1:0] id_op1;
    logic [XLEN-1:0] id_op2;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_aluop;
    logic            id_alusrc;
    logic            id_memrd;
    logic            id_memwr;
    logic            id_regwr;
    logic            id_illegal;
    logic            br_taken;
    logic [XLEN-1:0] br_target;

    modport master (
        output if_valid, if_instr, if_pc, wb_en, wb_rd, wb_data, fwd_rd, fwd_data, id_ready,
        input  if_ready, id_valid, id_rd, id_rs1, id_rs2, id_op1, id_op2, id_imm, id_aluop,
               id_alusrc, id_memrd, id_memwr, id_regwr, id_illegal, br_taken, br_target
    );

    modport slave (
        input  if_valid, if_instr, if_pc, wb_en, wb_rd, wb_data, fwd_rd, fwd_data, id_ready,
        output if_ready, id_valid, id_rd, id_rs1, id_rs2, id_op1, id_op2, id_imm, id_aluop,
               id_alusrc, id_memrd, id_memwr, id_regwr, id_illegal, br_taken, br_target
    );
endinterface

// File: rtl/id_stage_param.sv
// RV32I/RV32E decode stage: register file, decode, hazards, ID/EX register.
// Optional macro ID_BRANCH_EN resolves beq/bne/jal/jalr in this stage.
module id_stage_param #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    id_stage_param_if.slave bus
);
    localparam int RW = $clog2(NREG);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL  = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR   = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG  = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [3:0]      aluop;
        logic            alusrc;
        logic            memrd;
        logic            memwr;
        logic            regwr;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] regs [NREG];
    idex_t           q, d;

    logic [31:0]     ins;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rs1f, rs2f, rdf;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rv1, rv2, fv1, fv2, jalr_sum;
    logic            use1, use2, legal, oob, is_jal, is_jalr;
    logic            hit, load_use, br_haz, adv, if_ready, accept;

    assign ins  = bus.if_instr;
    assign opc  = ins[6:0];
    assign rdf  = ins[11:7];
    assign f3   = ins[14:12];
    assign rs1f = ins[19:15];
    assign rs2f = ins[24:20];
    assign f7   = ins[31:25];

    assign imm_i = XLEN'($signed(ins[31:20]));
    assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
    assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

    // Register file write is independent of stalls; x0 and out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.wb_en && bus.wb_rd != 5'd0 && int'(bus.wb_rd) < NREG) begin
            regs[bus.wb_rd[RW-1:0]] <= bus.wb_data;
        end
    end

    // Reads are write-through so a same-cycle write-back is visible to decode.
    always_comb begin
        rv1 = '0;
        rv2 = '0;
        if (rs1f != 5'd0 && int'(rs1f) < NREG)
            rv1 = (bus.wb_en && bus.wb_rd == rs1f) ? bus.wb_data : regs[rs1f[RW-1:0]];
        if (rs2f != 5'd0 && int'(rs2f) < NREG)
            rv2 = (bus.wb_en && bus.wb_rd == rs2f) ? bus.wb_data : regs[rs2f[RW-1:0]];
    end

    assign fv1 = (rs1f != 5'd0 && rs1f == bus.fwd_rd) ? bus.fwd_data : rv1;
    assign fv2 = (rs2f != 5'd0 && rs2f == bus.fwd_rd) ? bus.fwd_data : rv2;

    always_comb begin
        d         = '0;
        use1      = 1'b0;
        use2      = 1'b0;
        legal     = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        d.valid   = 1'b1;
        d.rd      = rdf;
        d.rs1     = rs1f;
        d.rs2     = rs2f;
        d.op1     = rv1;
        d.op2     = rv2;
        d.aluop   = ALU_ADD;
        case (opc)
            OP_LUI, OP_AUIPC: begin
                legal    = 1'b1;
                d.rs1    = '0;
                d.rs2    = '0;
                d.op1    = (opc == OP_AUIPC) ? bus.if_pc : '0;
                d.op2    = '0;
                d.imm    = imm_u;
                d.alusrc = 1'b1;
                d.regwr  = 1'b1;
            end
            // Link ops compute pc + 4 in EX; the jump itself is handled here.
            OP_JAL, OP_JALR: begin
                legal    = (opc == OP_JAL) || (f3 == 3'b000);
                use1     = (opc == OP_JALR);
                is_jal   = (opc == OP_JAL);
                is_jalr  = (opc == OP_JALR);
                d.rs1    = '0;
                d.rs2    = '0;
                d.op1    = bus.if_pc;
                d.op2    = '0;
                d.imm    = XLEN'(4);
                d.alusrc = 1'b1;
                d.regwr  = 1'b1;
            end
            OP_BR: begin
                legal   = (f3[2:1] == 2'b00);
                use1    = 1'b1;
                use2    = 1'b1;
                d.rd    = '0;
                d.op1   = fv1;
                d.op2   = fv2;
                d.imm   = imm_b;
                d.aluop = ALU_SUB;
            end
            OP_LOAD: begin
                legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                           (f3 == 3'b100) || (f3 == 3'b101);
                use1     = 1'b1;
                d.rs2    = '0;
                d.op2    = '0;
                d.imm    = imm_i;
                d.alusrc = 1'b1;
                d.memrd  = 1'b1;
                d.regwr  = 1'b1;
            end
            OP_STORE: begin
                legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                use1     = 1'b1;
                use2     = 1'b1;
                d.rd     = '0;
                d.imm    = imm_s;
                d.alusrc = 1'b1;
                d.memwr  = 1'b1;
            end
            OP_IMM: begin
                legal    = 1'b1;
                use1     = 1'b1;
                d.rs2    = '0;
                d.op2    = '0;
                d.imm    = imm_i;
                d.alusrc = 1'b1;
                d.regwr  = 1'b1;
                case (f3)
                    3'b000: d.aluop = ALU_ADD;
                    3'b010: d.aluop = ALU_SLT;
                    3'b100: d.aluop = ALU_XOR;
                    3'b110: d.aluop = ALU_OR;
                    3'b111: d.aluop = ALU_AND;
                    3'b001: begin d.aluop = ALU_SLL; legal = (f7 == 7'b0000000); end
                    3'b101: begin
                        d.aluop = f7[5] ? ALU_SRA : ALU_SRL;
                        legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_REG: begin
                legal   = 1'b1;
                use1    = 1'b1;
                use2    = 1'b1;
                d.regwr = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: d.aluop = ALU_ADD;
                    10'b0100000_000: d.aluop = ALU_SUB;
                    10'b0000000_001: d.aluop = ALU_SLL;
                    10'b0000000_010: d.aluop = ALU_SLT;
                    10'b0000000_100: d.aluop = ALU_XOR;
                    10'b0000000_101: d.aluop = ALU_SRL;
                    10'b0100000_101: d.aluop = ALU_SRA;
                    10'b0000000_110: d.aluop = ALU_OR;
                    10'b0000000_111: d.aluop = ALU_AND;
                    default:         legal   = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        oob = (use1 && int'(rs1f) >= NREG) || (use2 && int'(rs2f) >= NREG) ||
              (d.regwr && int'(rdf) >= NREG);
        if (!legal || oob) begin
            d.illegal = 1'b1;
            d.regwr   = 1'b0;
            d.memrd   = 1'b0;
            d.memwr   = 1'b0;
            is_jal    = 1'b0;
            is_jalr   = 1'b0;
        end
    end

    assign hit      = q.valid && q.rd != 5'd0 &&
                      ((use1 && rs1f == q.rd) || (use2 && rs2f == q.rd));
    assign load_use = hit && q.memrd;
    assign adv      = !q.valid || bus.id_ready;
    assign if_ready = adv && !load_use && !br_haz;
    assign accept   = bus.if_valid && if_ready;

    assign jalr_sum      = fv1 + imm_i;
    assign bus.br_target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} :
                           is_jal  ? bus.if_pc + imm_j : bus.if_pc + imm_b;

`ifdef ID_BRANCH_EN
    logic is_br, eq;
    assign is_br = (opc == OP_BR) && !d.illegal;
    assign eq    = (fv1 == fv2);
    // Compare operands come from EX/MEM or the register file, so a producer still in ID/EX must stall.
    assign br_haz       = hit && q.regwr && (is_br || is_jalr);
    assign bus.br_taken = accept && (is_jal || is_jalr || (is_br && (eq ^ f3[0])));
`else
    assign br_haz       = 1'b0;
    assign bus.br_taken = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)   q <= '0;
        else if (adv) q <= accept ? d : '0;
    end

    assign bus.if_ready   = if_ready;
    assign bus.id_valid   = q.valid;
    assign bus.id_rd      = q.rd;
    assign bus.id_rs1     = q.rs1;
    assign bus.id_rs2     = q.rs2;
    assign bus.id_op1     = q.op1;
    assign bus.id_op2     = q.op2;
    assign bus.id_imm     = q.imm;
    assign bus.id_aluop   = q.aluop;
    assign bus.id_alusrc  = q.alusrc;
    assign bus.id_memrd   = q.memrd;
    assign bus.id_memwr   = q.memwr;
    assign bus.id_regwr   = q.regwr;
    assign bus.id_illegal = q.illegal;
endmodule

// File: tb/tb_id_stage_param.sv
module tb_id_stage_param;
  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  logic done = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

`ifdef ID_BRANCH_EN
  localparam logic BR_EN = 1'b1;
`else
  localparam logic BR_EN = 1'b0;
`endif

  localparam int MAX_CYC = 2000;

  always #5 gclk = ~gclk;

  id_stage_param_if #(.XLEN(32)) bus ();
  id_stage_param_if #(.XLEN(32)) bus16 ();

  id_stage_param #(.XLEN(32), .NREG(32)) dut   (.clk(gclk), .rst_n(grst_n), .bus(bus));
  id_stage_param #(.XLEN(32), .NREG(16)) dut16 (.clk(gclk), .rst_n(grst_n), .bus(bus16));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  always @(posedge gclk) begin
    cyc <= cyc + 1;
    if (!done && cyc >= MAX_CYC) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout: sequence not finished after %0d cycles", MAX_CYC);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  initial begin
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.id_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
    bus16.if_valid = 1'b0; bus16.if_instr = '0; bus16.if_pc = '0; bus16.id_ready = 1'b1;
    bus16.wb_en = 1'b0; bus16.wb_rd = '0; bus16.wb_data = '0; bus16.fwd_rd = '0; bus16.fwd_data = '0;

    tick; tick;
    chk("rst_valid", bus.id_valid, 1'b0);
    chk("rst_op1", bus.id_op1, 32'h0);
    chk("rst_regwr", bus.id_regwr, 1'b0);
    chk("rst_valid16", bus16.id_valid, 1'b0);
    grst_n = 1'b1;

    offer(32'h00500093, 32'h0);
    #1 chk("t1_ready", bus.if_ready, 1'b1);
    tick;
    chk("t1_valid", bus.id_valid, 1'b1);
    chk("t1_op1", bus.id_op1, 32'h0);
    chk("t1_imm", bus.id_imm, 32'h5);
    chk("t1_alusrc", bus.id_alusrc, 1'b1);
    chk("t1_regwr", bus.id_regwr, 1'b1);
    chk("t1_rd", bus.id_rd, 5'd1);

    offer(32'h0000A103, 32'h4);
    #1 chk("t2_lw_ready", bus.if_ready, 1'b1);
    tick;
    chk("t2_lw_memrd", bus.id_memrd, 1'b1);
    offer(32'h001101B3, 32'h8);
    #1 chk("t2_haz_ready", bus.if_ready, 1'b0);
    tick;
    chk("t2_bubble", bus.id_valid, 1'b0);
    chk("t2_bubble_memrd", bus.id_memrd, 1'b0);
    #1 chk("t2_ready_again", bus.if_ready, 1'b1);
    tick;
    chk("t2_add_valid", bus.id_valid, 1'b1);
    chk("t2_add_rd", bus.id_rd, 5'd3);
    chk("t2_add_rs1", bus.id_rs1, 5'd2);

    bus.id_ready = 1'b0;
    offer(32'h401183B3, 32'hC);
    wb(1'b1, 5'd4, 32'h77);
    #1 chk("t3_stall_ready", bus.if_ready, 1'b0);
    tick; tick; tick;
    chk("t3_hold_rd", bus.id_rd, 5'd3);
    chk("t3_hold_valid", bus.id_valid, 1'b1);
    chk("t3_hold_rs1", bus.id_rs1, 5'd2);
    wb(1'b0, 5'd0, 32'h0);
    bus.id_ready = 1'b1;
    offer(32'hFE40AE23, 32'h10);
    tick;
    chk("t3_x4", bus.id_op2, 32'h77);
    chk("t3_sw_imm", bus.id_imm, 32'hFFFFFFFC);
    chk("t3_sw_memwr", bus.id_memwr, 1'b1);
    chk("t3_sw_regwr", bus.id_regwr, 1'b0);
    offer(32'h401183B3, 32'h14);
    tick;
    chk("sub_aluop", bus.id_aluop, 4'd1);

    offer(32'h00628863, 32'h100);
    wb(1'b1, 5'd6, 32'h9);
    bus.fwd_rd = 5'd0; bus.fwd_data = 32'h9;
    #1 chk("t4_nofwd_taken", bus.br_taken, 1'b0);
    bus.fwd_rd = 5'd5;
    #1 chk("t4_taken", bus.br_taken, BR_EN);
    chk("t4_target", bus.br_target, 32'h110);
    tick;
    chk("t4_op1", bus.id_op1, 32'h9);
    chk("t4_op2", bus.id_op2, 32'h9);
    chk("t4_aluop", bus.id_aluop, 4'd1);
    chk("t4_regwr", bus.id_regwr, 1'b0);
    bus.if_valid = 1'b0;
    bus.fwd_rd = 5'd0;
    wb(1'b1, 5'd7, 32'h200);
    tick;
    wb(1'b0, 5'd0, 32'h0);

    offer(32'h003380E7, 32'h300);
    #1 chk("t6_taken", bus.br_taken, BR_EN);
    chk("t6_target", bus.br_target, 32'h202);
    tick;
    chk("t6_op1", bus.id_op1, 32'h300);
    chk("t6_imm", bus.id_imm, 32'h4);
    chk("t6_rs1", bus.id_rs1, 5'd0);
    chk("t6_regwr", bus.id_regwr, 1'b1);

    offer(32'h00008463, 32'h304);
    #1 chk("bh_ready", bus.if_ready, !BR_EN);
    chk("bh_taken", bus.br_taken, 1'b0);
    offer(32'hFFFFFFFF, 32'h304);
    tick;
    chk("ill_flag", bus.id_illegal, 1'b1);
    chk("ill_valid", bus.id_valid, 1'b1);
    chk("ill_regwr", bus.id_regwr, 1'b0);

    offer(32'h0080006F, 32'h40);
    bus.if_valid = 1'b0;
    #1 chk("jal_idle_taken", bus.br_taken, 1'b0);
    chk("jal_target", bus.br_target, 32'h48);
    bus.if_valid = 1'b1;
    #1 chk("jal_taken", bus.br_taken, BR_EN);
    tick;
    chk("jal_op1", bus.id_op1, 32'h40);
    chk("jal_imm", bus.id_imm, 32'h4);

    offer(32'h0000A103, 32'h44);
    tick;
    offer(32'h001101B3, 32'h48);
    #1 chk("rs_stall", bus.if_ready, 1'b0);
    grst_n = 1'b0;
    tick;
    chk("rs_valid", bus.id_valid, 1'b0);
    chk("rs_ready", bus.if_ready, 1'b1);
    grst_n = 1'b1;
    offer(32'hFE40AE23, 32'h4C);
    tick;
    chk("rs_x4_cleared", bus.id_op2, 32'h0);
    bus.if_valid = 1'b0;

    bus16.if_valid = 1'b1; bus16.if_instr = 32'h00208A33; bus16.if_pc = 32'h0;
    bus16.wb_en = 1'b1; bus16.wb_rd = 5'd20; bus16.wb_data = 32'hAB;
    tick;
    chk("t5_illegal", bus16.id_illegal, 1'b1);
    chk("t5_regwr", bus16.id_regwr, 1'b0);
    chk("t5_valid", bus16.id_valid, 1'b1);
    bus16.wb_en = 1'b0;
    bus16.if_instr = 32'h000202B3;
    tick;
    chk("t5_x4_untouched", bus16.id_op1, 32'h0);
    chk("t5_legal", bus16.id_illegal, 1'b0);
    chk("t5_add_regwr", bus16.id_regwr, 1'b1);
    bus16.if_valid = 1'b0;

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
